// File: rtl/pl_reg_ir_skid_if.sv
// pl_reg_ir_skid_if: fetch->decode handshake bundle for the IF/ID skid register
// Signals: in_valid/in_ready/in_pc/in_pc4/in_inst (fetch side),
//   out_valid/out_ready/out_pc/out_pc4/out_inst/out_misalign (decode side).
// slave modport is the register itself; master modport is the fetch/decode environment.
// Option: PL_IR_PRED_EN adds in_pred_taken/in_pred_tgt and out_pred_taken/out_pred_tgt.
interface pl_reg_ir_skid_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_pc4;
  logic [31:0]     in_inst;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc4;
  logic [31:0]     out_inst;
  logic            out_misalign;
`ifdef PL_IR_PRED_EN
  logic            in_pred_taken;
  logic [XLEN-1:0] in_pred_tgt;
  logic            out_pred_taken;
  logic [XLEN-1:0] out_pred_tgt;
`endif
  modport slave (
    input  in_valid, in_pc, in_pc4, in_inst, out_ready,
`ifdef PL_IR_PRED_EN
    input  in_pred_taken, in_pred_tgt,
    output out_pred_taken, out_pred_tgt,
`endif
    output in_ready, out_valid, out_pc, out_pc4, out_inst, out_misalign
  );
  modport master (
    output in_valid, in_pc, in_pc4, in_inst, out_ready,
`ifdef PL_IR_PRED_EN
    output in_pred_taken, in_pred_tgt,
    input  out_pred_taken, out_pred_tgt,
`endif
    input  in_ready, out_valid, out_pc, out_pc4, out_inst, out_misalign
  );
endinterface

// File: rtl/pl_reg_ir_skid.sv
// pl_reg_ir_skid: IF/ID pipeline register with valid/ready handshake and 2-entry skid buffer
// Ports: clk; rst (synchronous, active-high, overrides flush);
//   flush (kills MAIN and SKID, discards the same-cycle input);
//   bus (slave modport of pl_reg_ir_skid_if): fetch in_* and decode out_* handshakes.
// Option: define PL_IR_PRED_EN to carry branch prediction (taken/target) with each entry.
module pl_reg_ir_skid #(
  parameter int              XLEN     = 32,
  parameter logic [31:0]     NOP_INST = 32'h0000_0013,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic             clk,
  input logic             rst,
  input logic             flush,
  pl_reg_ir_skid_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, MAIN, BOTH} state_t;
  typedef struct packed {
`ifdef PL_IR_PRED_EN
    logic            pred_taken;
    logic [XLEN-1:0] pred_tgt;
`endif
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [31:0]     inst;
  } entry_t;
  state_t state;
  entry_t m, s, in_e, rst_e;
  logic in_rdy, vld, acc, con;
  always_comb begin
    in_e = '0;
    in_e.pc = bus.in_pc;
    in_e.pc4 = bus.in_pc4;
    in_e.inst = bus.in_inst;
`ifdef PL_IR_PRED_EN
    in_e.pred_taken = bus.in_pred_taken;
    in_e.pred_tgt = bus.in_pred_tgt;
`endif
    rst_e = '0;
    rst_e.pc = RESET_PC;
    rst_e.pc4 = RESET_PC;
    rst_e.inst = NOP_INST;
  end
  assign vld = state != EMPTY;
  assign acc = bus.in_valid & in_rdy;
  assign con = vld & bus.out_ready;
  // in_rdy is kept equal to (state != BOTH) by updating it alongside every state change
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= EMPTY;
      in_rdy <= 1'b1;
      m <= rst_e;
      s <= rst_e;
    end else begin
      case (state)
        EMPTY: if (acc) begin
          state <= MAIN;
          m <= in_e;
        end
        MAIN: if (acc && con) m <= in_e;
          else if (acc) begin
            state <= BOTH;
            in_rdy <= 1'b0;
            s <= in_e;
          end else if (con) state <= EMPTY;
        BOTH: if (con) begin
          state <= MAIN;
          in_rdy <= 1'b1;
          m <= s;
        end
        default: begin
          state <= EMPTY;
          in_rdy <= 1'b1;
        end
      endcase
    end
  end
  assign bus.in_ready = in_rdy;
  assign bus.out_valid = vld;
  assign bus.out_pc = m.pc;
  assign bus.out_pc4 = m.pc4;
  assign bus.out_inst = vld ? m.inst : NOP_INST;
  assign bus.out_misalign = vld & |m.pc[1:0];
`ifdef PL_IR_PRED_EN
  assign bus.out_pred_taken = vld & m.pred_taken;
  assign bus.out_pred_tgt = vld ? m.pred_tgt : '0;
`endif
endmodule
